// File: rtl/commit_unit_pkg.sv
// commit_unit_pkg: shared sizing, register/data types and commit FSM states for the commit unit and ROB.
package commit_unit_pkg;
  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 16;
  localparam int RETIRE_W = 3;
  localparam int WR_PORTS = 2;
  localparam int REG_W    = $clog2(NUM_REGS);
  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  typedef enum logic [0:0] {S_IDLE = IDLE, S_DRAIN = DRAIN} state_t;
endpackage

// File: rtl/commit_unit_if.sv
// commit_unit_if: ROB-to-commit retire bundle handshake; master is the ROB, slave the commit unit.
interface commit_unit_if #(
  parameter int NUM_REGS = commit_unit_pkg::NUM_REGS,
  parameter int DATA_W   = commit_unit_pkg::DATA_W,
  parameter int RETIRE_W = commit_unit_pkg::RETIRE_W,
  parameter int WR_PORTS = commit_unit_pkg::WR_PORTS
);
  logic                                          retire_valid;
  logic [$clog2(RETIRE_W+1)-1:0]                 retire_count;
  logic [RETIRE_W-1:0][$clog2(NUM_REGS)-1:0]     retire_targets;
  logic [RETIRE_W-1:0][DATA_W-1:0]               retire_values;
  logic                                          retire_ready;
  logic [$clog2(WR_PORTS+1)-1:0]                 retired_num;
  modport master (output retire_valid, retire_count, retire_targets, retire_values,
                  input  retire_ready, retired_num);
  modport slave  (input  retire_valid, retire_count, retire_targets, retire_values,
                  output retire_ready, retired_num);
endinterface

// File: rtl/commit_unit_arch_regfile.sv
// arch_regfile: architectural register file, multi-port write (higher port wins), two combinational reads.
module arch_regfile #(
  parameter int NUM_REGS = commit_unit_pkg::NUM_REGS,
  parameter int DATA_W   = commit_unit_pkg::DATA_W,
  parameter int WR_PORTS = commit_unit_pkg::WR_PORTS
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [WR_PORTS-1:0]                          we,
  input  logic [WR_PORTS-1:0][$clog2(NUM_REGS)-1:0]    wa,
  input  logic [WR_PORTS-1:0][DATA_W-1:0]              wd,
  input  logic [$clog2(NUM_REGS)-1:0]                  ra_a,
  input  logic [$clog2(NUM_REGS)-1:0]                  ra_b,
  output logic [DATA_W-1:0]                            rd_a,
  output logic [DATA_W-1:0]                            rd_b
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else
      for (int p = 0; p < WR_PORTS; p++) if (we[p]) regs[wa[p]] <= wd[p];
  assign rd_a = regs[ra_a];
  assign rd_b = regs[ra_b];
endmodule

// File: rtl/commit_unit.sv
// commit_unit: retires up to 3 instructions per bundle into a 2-write-port register file, spilling slot 2 via a hold register.
// Optional macro COMMIT_BYPASS_EN forwards same-edge writes onto the read ports.
module commit_unit #(
  parameter int NUM_REGS = commit_unit_pkg::NUM_REGS,
  parameter int DATA_W   = commit_unit_pkg::DATA_W,
  parameter int RETIRE_W = commit_unit_pkg::RETIRE_W,
  parameter int WR_PORTS = commit_unit_pkg::WR_PORTS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  commit_unit_if.slave                rif,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr_a,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr_b,
  output logic [DATA_W-1:0]           rd_data_a,
  output logic [DATA_W-1:0]           rd_data_b,
  output logic [31:0]                 commit_count
);
  import commit_unit_pkg::*;
  localparam int RW = $clog2(NUM_REGS);
  state_t                          state;
  logic [RW-1:0]                   hold_t;
  logic [DATA_W-1:0]               hold_v;
  logic [WR_PORTS-1:0]             we;
  logic [WR_PORTS-1:0][RW-1:0]     wa;
  logic [WR_PORTS-1:0][DATA_W-1:0] wd;
  logic [DATA_W-1:0]               st_a, st_b;
  logic [1:0]                      num;
  logic                            drain, acc, spill;
  assign drain            = state == S_DRAIN;
  assign rif.retire_ready = !drain;
  assign acc              = rif.retire_valid && rif.retire_ready;
  assign spill            = acc && (&rif.retire_count);
  // In DRAIN the held slot-2 instruction reuses write port 0; port 1 is the younger slot.
  always_comb begin
    we    = '0;
    wa    = '0;
    wd    = '0;
    we[0] = drain || (acc && |rif.retire_count);
    wa[0] = drain ? hold_t : rif.retire_targets[0];
    wd[0] = drain ? hold_v : rif.retire_values[0];
    we[1] = acc && rif.retire_count[1];
    wa[1] = rif.retire_targets[1];
    wd[1] = rif.retire_values[1];
    num   = {1'b0, we[0]} + {1'b0, we[1]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state           <= S_IDLE;
      hold_t          <= '0;
      hold_v          <= '0;
      rif.retired_num <= '0;
      commit_count    <= '0;
    end else begin
      state           <= spill ? S_DRAIN : S_IDLE;
      if (spill) begin
        hold_t <= rif.retire_targets[2];
        hold_v <= rif.retire_values[2];
      end
      rif.retired_num <= num;
      commit_count    <= commit_count + {30'd0, num};
    end
  arch_regfile #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .WR_PORTS(WR_PORTS)) u_rf (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra_a(rd_addr_a), .ra_b(rd_addr_b), .rd_a(st_a), .rd_b(st_b)
  );
`ifdef COMMIT_BYPASS_EN
  assign rd_data_a = (we[1] && wa[1] == rd_addr_a) ? wd[1] : (we[0] && wa[0] == rd_addr_a) ? wd[0] : st_a;
  assign rd_data_b = (we[1] && wa[1] == rd_addr_b) ? wd[1] : (we[0] && wa[0] == rd_addr_b) ? wd[0] : st_b;
`else
  assign rd_data_a = st_a;
  assign rd_data_b = st_b;
`endif
endmodule

// File: doc/commit_unit.md
COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, architectural register count; also ROB depth.
REQ-002 SHALL have parameter DATA_W, default 16, register/result width.
REQ-003 SHALL have parameter RETIRE_W, default 3, maximum instructions offered per retire bundle.
REQ-004 SHALL have parameter WR_PORTS, default 2, register-file writes per cycle.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  reset: asynchronous, active-low.
REQ-007 retire_valid  input  1  retire bundle offered by the ROB.
REQ-008 retire_count  input  2  instructions in bundle, 0..3; slot 0 oldest.
REQ-009 retire_targets  input  3x4  destination register per slot.
REQ-010 retire_values  input  3x16  result value per slot.
REQ-011 retire_ready  output  1  bundle can be accepted this cycle.
REQ-012 retired_num  output  2  registered; instructions written to the register file in the previous cycle; ROB advances its tail by this amount.
REQ-013 rd_addr_a, rd_addr_b  input  4 each  operand read addresses.
REQ-014 rd_data_a, rd_data_b  output  16 each  operand read data, combinational.
REQ-015 commit_count  output  32  running total of committed instructions.

Function
REQ-016 Handshake SHALL be: bundle accepted on a rising edge where retire_valid && retire_ready; retire_ready combinational, high only in state IDLE.
REQ-017 FSM SHALL have states IDLE and DRAIN.
REQ-018 IDLE, accepted count 0: no write, stay IDLE.
REQ-019 IDLE, accepted count 1 or 2: write the slots at the accepting edge, stay IDLE.
REQ-020 IDLE, accepted count 3: write slots 0 and 1, latch slot 2 target/value into a hold register, go to DRAIN.
REQ-021 DRAIN: write the hold register at the next edge, ignore all retire inputs, return to IDLE.
REQ-022 Same-edge writes to one target SHALL resolve youngest-wins (slot 1 over slot 0).
REQ-023 Writes SHALL be visible on rd_data one cycle after the writing edge (absent bypass).
REQ-024 retired_num SHALL equal writes performed at the last edge: 0, 1 or 2.
REQ-025 commit_count SHALL add retired_num's next value each edge, wrapping modulo 2^32.
REQ-026 All registers, including register 0, SHALL be writable; there is no hard-wired zero.
REQ-027 retire_targets/values are don't-care for slots at or above retire_count and when not accepted.

Reset
REQ-028 On rst_n low, state SHALL be IDLE, all registers 0, hold register 0, retired_num 0, commit_count 0, immediately and independent of clk.
REQ-029 Reset during DRAIN SHALL discard the held slot-2 instruction.
REQ-030 retire_ready SHALL be 1 while in reset and on the first edge after deassertion.

Configuration
REQ-031 Macro COMMIT_BYPASS_EN defined: rd_data_x SHALL forward the youngest write occurring at the coming edge whose target equals rd_addr_x (hold register in DRAIN; slot 1 over slot 0 in IDLE).
REQ-032 Macro COMMIT_BYPASS_EN undefined: rd_data_x SHALL be the stored register value only.

Structure
REQ-033 Shared package SHALL hold NUM_REGS, DATA_W, RETIRE_W, WR_PORTS, the reg-index/data typedefs, and the FSM state enum; the ROB imports the same package.
REQ-034 Register storage SHALL be a sub-module arch_regfile (2 write ports, 2 combinational read ports, async reset clear).

Verification
REQ-035 Reset, then read r0..r15 -> all 0; retire_ready=1; commit_count=0.
REQ-036 Bundle count=2: (r3,0x1111),(r5,0x2222) -> next cycle r3=0x1111, r5=0x2222, retired_num=2, commit_count=2.
REQ-037 Bundle count=3: (r1,0xA),(r2,0xB),(r3,0xC) -> cycle 1 retire_ready=0, r1/r2 written, retired_num=2; cycle 2 r3=0xC, retired_num=1, retire_ready=1; commit_count=3.
REQ-038 Bundle count=2 with both slots targeting r7: (0x1234),(0x5678) -> r7=0x5678.
REQ-039 With COMMIT_BYPASS_EN, rd_addr_a=r9 while writing (r9,0xBEEF) -> rd_data_a=0xBEEF in the same cycle; without the macro -> old r9 value.
REQ-040 Bundle count=3, assert rst_n low during DRAIN -> r3 remains 0, state IDLE, commit_count=0.
